// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// Holds the state encoding, default widths and the round-robin pick function.
package fifo_pkg;

    localparam int FIFO_DATA_W   = 8;
    localparam int ARB_MAX_BURST = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } arb_state_t;

    // Two-way round-robin select; rr_ptr breaks the tie when both request.
    function automatic arb_state_t rr_pick(input logic rr_ptr, input logic req0, input logic req1);
        arb_state_t pick;
        if (req0 && req1) begin
            pick = rr_ptr ? SERVE1 : SERVE0;
        end else if (req0) begin
            pick = SERVE0;
        end else if (req1) begin
            pick = SERVE1;
        end else begin
            pick = IDLE;
        end
        return pick;
    endfunction

    function automatic logic [1:0] state_grant(input arb_state_t st);
        logic [1:0] g;
        case (st)
            SERVE0:  g = 2'b01;
            SERVE1:  g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter.sv
// Shares the FIFO write port between two request/ack producers with
// round-robin bounded bursts and full/almost-full throttling.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int MAX_BURST = ARB_MAX_BURST,
    parameter int CNT_W     = 16
) (
    input  logic              wr_clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] din0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] din1,
    output logic              ack1,
    input  logic              f_full,
    input  logic              f_almost_full,
    output logic [DATA_W-1:0] data_in,
    output logic              enable_wr,
    output logic [1:0]        grant,
    output logic [CNT_W-1:0]  wr_count0,
    output logic [CNT_W-1:0]  wr_count1
);

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    arb_state_t        state_r;
    arb_state_t        state_next_s;
    logic              rr_ptr_r;
    logic              rr_next_s;
    logic [3:0]        burst_cnt_r;
    logic [3:0]        burst_next_s;
    logic [DATA_W-1:0] data_in_r;
    logic              enable_wr_r;
    logic [1:0]        grant_r;
    logic [CNT_W-1:0]  cnt0_r;
    logic [CNT_W-1:0]  cnt1_r;

    logic can_write_s;
    logic ack0_s;
    logic ack1_s;
    logic serve1_s;
    logic own_req_s;
    logic oth_req_s;
    logic own_ack_s;

    // Near full, the just-issued write must land before another is allowed.
    assign can_write_s = !f_full && !(f_almost_full && enable_wr_r);
    assign ack0_s      = reset_n && grant_r[0] && req0 && can_write_s;
    assign ack1_s      = reset_n && grant_r[1] && req1 && can_write_s;

    assign serve1_s  = (state_r == SERVE1);
    assign own_req_s = serve1_s ? req1 : req0;
    assign oth_req_s = serve1_s ? req0 : req1;
    assign own_ack_s = serve1_s ? ack1_s : ack0_s;

    // Next-state, round-robin pointer and burst counter decode.
    always_comb begin
        state_next_s = state_r;
        rr_next_s    = rr_ptr_r;
        burst_next_s = burst_cnt_r;
        case (state_r)
            IDLE: begin
                state_next_s = rr_pick(rr_ptr_r, req0, req1);
            end
            SERVE0, SERVE1: begin
                if ((own_ack_s && (burst_cnt_r == BURST_LAST)) || !own_req_s) begin
                    burst_next_s = 4'd0;
                    if (oth_req_s) begin
                        state_next_s = serve1_s ? SERVE0 : SERVE1;
                        rr_next_s    = !serve1_s;
                    end else if (own_req_s) begin
                        state_next_s = state_r;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else if (own_ack_s) begin
                    burst_next_s = burst_cnt_r + 4'd1;
                end else begin
                    burst_next_s = burst_cnt_r;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Registered state, FIFO write port and accepted-word counters.
    always_ff @(posedge wr_clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            rr_ptr_r    <= 1'b0;
            burst_cnt_r <= 4'd0;
            data_in_r   <= '0;
            enable_wr_r <= 1'b0;
            grant_r     <= 2'b00;
            cnt0_r      <= '0;
            cnt1_r      <= '0;
        end else begin
            state_r     <= state_next_s;
            rr_ptr_r    <= rr_next_s;
            burst_cnt_r <= burst_next_s;
            grant_r     <= state_grant(state_next_s);
            if (ack0_s) begin
                data_in_r   <= din0;
                enable_wr_r <= 1'b1;
                cnt0_r      <= cnt0_r + CNT_W'(1);
            end else if (ack1_s) begin
                data_in_r   <= din1;
                enable_wr_r <= 1'b1;
                cnt1_r      <= cnt1_r + CNT_W'(1);
            end else begin
                enable_wr_r <= 1'b0;
            end
        end
    end

    assign ack0      = ack0_s;
    assign ack1      = ack1_s;
    assign data_in   = data_in_r;
    assign enable_wr = enable_wr_r;
    assign grant     = grant_r;
    assign wr_count0 = cnt0_r;
    assign wr_count1 = cnt1_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes the expected FIFO write
// stream, a monitor pops it whenever enable_wr is seen.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1;
    logic [7:0]  din0, din1;
    logic        ack0, ack1;
    logic        f_full, f_almost_full;
    logic [7:0]  data_in;
    logic        enable_wr;
    logic [1:0]  grant;
    logic [15:0] wr_count0, wr_count1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] w0[$];
    logic [7:0] w1[$];
    bit fair_mode = 1'b0;
    bit af_mode   = 1'b0;
    bit prev_we   = 1'b0;
    bit stop_prod = 1'b0;
    int fb0 = 0;
    int fb1 = 0;

    fifo_wr_arbiter #(.DATA_W(8), .MAX_BURST(4), .CNT_W(16)) dut (
        .wr_clk(clk), .reset_n(reset_n),
        .req0(req0), .din0(din0), .ack0(ack0),
        .req1(req1), .din1(din1), .ack1(ack1),
        .f_full(f_full), .f_almost_full(f_almost_full),
        .data_in(data_in), .enable_wr(enable_wr), .grant(grant),
        .wr_count0(wr_count0), .wr_count1(wr_count1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop expected word on every FIFO write; side checks per mode.
    always @(negedge clk) begin
        if (enable_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'd1, 32'd0);
            end else begin
                chk("wr_data", {24'd0, data_in}, {24'd0, exp_q.pop_front()});
            end
        end
        if (fair_mode) begin
            int d;
            d = (int'(wr_count0) - fb0) - (int'(wr_count1) - fb1);
            chk("fair_gap", {31'd0, (d <= 4 && d >= -4)}, 32'd1);
        end
        if (af_mode) begin
            chk("af_no_b2b", {31'd0, (prev_we && (enable_wr === 1'b1))}, 32'd0);
            prev_we = (enable_wr === 1'b1);
        end
    end

    task automatic produce0(input int n);
        logic got;
        for (int i = 0; i < n; i++) begin
            din0 = w0[i];
            req0 = 1'b1;
            got  = 1'b0;
            for (int c = 0; c < 100 && !got && !stop_prod; c++) begin
                @(negedge clk);
                got = ack0;
                @(posedge clk);
                #1;
            end
            if (stop_prod) break;
            if (!got) chk("p0_timeout", 32'd0, 32'd1);
        end
        req0 = 1'b0;
    endtask

    task automatic produce1(input int n);
        logic got;
        for (int i = 0; i < n; i++) begin
            din1 = w1[i];
            req1 = 1'b1;
            got  = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                got = ack1;
                @(posedge clk);
                #1;
            end
            if (!got) chk("p1_timeout", 32'd0, 32'd1);
        end
        req1 = 1'b0;
    endtask

    task automatic wait_cnt0(input logic [15:0] tgt);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge clk);
            #1;
            hit = (wr_count0 == tgt);
        end
        if (!hit) chk("cnt_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic end_checks(input string tag, input logic [15:0] c0, input logic [15:0] c1);
        @(negedge clk);
        chk({tag, "_cnt0"}, {16'd0, wr_count0}, {16'd0, c0});
        chk({tag, "_cnt1"}, {16'd0, wr_count1}, {16'd0, c1});
        chk({tag, "_q_empty"}, exp_q.size(), 32'd0);
        chk({tag, "_grant_idle"}, {30'd0, grant}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
        din0 = 8'h00; din1 = 8'h00; f_full = 1'b0; f_almost_full = 1'b0;

        // Reset with both requests high: nothing accepted, everything cleared.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_ack0", {31'd0, ack0}, 32'd0);
            chk("rst_ack1", {31'd0, ack1}, 32'd0);
            chk("rst_enable_wr", {31'd0, enable_wr}, 32'd0);
            chk("rst_grant", {30'd0, grant}, 32'd0);
            chk("rst_counts", {wr_count1, wr_count0}, 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel_grant", {30'd0, grant}, 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        idle(3);

        // Single producer stream across a burst boundary.
        w0 = '{8'h0A, 8'h10, 8'h41, 8'h13, 8'hAA, 8'hAB};
        foreach (w0[i]) exp_q.push_back(w0[i]);
        produce0(6);
        idle(3);
        end_checks("single", 16'd6, 16'd0);

        // Fairness: both producers contend, bursts of four alternate.
        w0 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        w1 = '{8'h81, 8'h82, 8'h83, 8'h84};
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h81, 8'h82, 8'h83, 8'h84,
                  8'h05, 8'h06, 8'h07, 8'h08};
        fb0 = int'(wr_count0); fb1 = int'(wr_count1);
        fair_mode = 1'b1;
        fork
            produce0(8);
            produce1(4);
        join
        idle(3);
        fair_mode = 1'b0;
        end_checks("fair", 16'd14, 16'd4);

        // Backpressure after word 2; the burst resumes with the same count,
        // so producer 1 must be served after exactly two more words.
        w0 = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        w1 = '{8'h91};
        exp_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h91, 8'h25, 8'h26};
        fork
            produce0(6);
            begin
                wait_cnt0(16'd16);
                f_full = 1'b1;
                fork
                    produce1(1);
                    begin
                        for (int k = 0; k < 5; k++) begin
                            @(negedge clk);
                            chk("full_ack0", {31'd0, ack0}, 32'd0);
                            chk("full_ack1", {31'd0, ack1}, 32'd0);
                            chk("full_grant", {30'd0, grant}, 32'd1);
                            if (k > 0) chk("full_enable_wr", {31'd0, enable_wr}, 32'd0);
                            @(posedge clk);
                            #1;
                        end
                        f_full = 1'b0;
                    end
                join
            end
        join
        idle(3);
        end_checks("bp", 16'd20, 16'd5);

        // Almost full: writes may not occur on consecutive cycles.
        w0 = '{8'h31, 8'h32, 8'h33, 8'h34};
        foreach (w0[i]) exp_q.push_back(w0[i]);
        f_almost_full = 1'b1;
        prev_we = 1'b0;
        af_mode = 1'b1;
        produce0(4);
        idle(3);
        af_mode = 1'b0;
        f_almost_full = 1'b0;
        end_checks("afull", 16'd24, 16'd5);

        // Reset after word 2 of a burst: in-flight write dropped, all cleared.
        w0 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        exp_q = '{8'h41, 8'h42};
        stop_prod = 1'b0;
        fork
            produce0(6);
            begin
                wait_cnt0(16'd26);
                reset_n = 1'b0;
                stop_prod = 1'b1;
                @(negedge clk);
                chk("mrst_ack0_forced", {31'd0, ack0}, 32'd0);
                @(posedge clk);
                @(negedge clk);
                chk("mrst_enable_wr", {31'd0, enable_wr}, 32'd0);
                chk("mrst_counts", {wr_count1, wr_count0}, 32'd0);
                chk("mrst_grant", {30'd0, grant}, 32'd0);
            end
        join
        idle(2);
        reset_n = 1'b1;
        idle(3);
        end_checks("mrst", 16'd0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
